ex_muldiv_ctrl: RTL and testbench



---
 rtl/ex_muldiv_ctrl_pkg.sv | 49 ++++
 rtl/muldiv_datapath.sv | 136 +++++++++++++
 rtl/ex_muldiv_ctrl.sv | 129 ++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - MD_MUL .. MD_REMU : operation codes (RV32M funct3)
//   - md_state_e        : sequencer states MD_IDLE / MD_CALC / MD_FIX
//   - MD_ITER           : number of radix-2 iterations (32)
//   - helpers classifying an op as divide and giving operand signedness
package ex_muldiv_ctrl_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam int unsigned MD_ITER = 32;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic md_a_signed(input logic [2:0] op);
    logic s;
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic md_b_signed(input logic [2:0] op);
    logic s;
    case (op)
      MD_MULH, MD_DIV, MD_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: 64-bit accumulator/shift register, adder/subtractor and
// negators of the iterative multiply/divide unit.
//   clk, reset_n          : clock, asynchronous active-low reset
//   load_i                : capture |operands| and sign flags from op_i/operand*_i
//   step_i                : perform one radix-2 iteration for op_q_i
//   op_i                  : op presented with the start request
//   op_q_i                : op of the operation in flight (selects step/result)
//   operand1_i/operand2_i : rs1 / rs2 values
//   fast_o                : op_i completes without iterating (IDLE -> FIX)
//   result_o              : sign-corrected, op-selected result (valid in FIX)
// Macro MULDIV_DIV_EN: when undefined, the divide step and fast-path
// comparators are left out and divide ops produce 0.
module muldiv_datapath
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [2:0]  op_i,
  input  logic [2:0]  op_q_i,
  input  logic [31:0] operand1_i,
  input  logic [31:0] operand2_i,
  output logic        fast_o,
  output logic [31:0] result_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;

  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [31:0] mcand;
  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic        div_zero, div_ovf;
  logic [33:0] diff;
`endif

  always_comb begin
    a_neg = md_a_signed(op_i) & operand1_i[31];
    b_neg = md_b_signed(op_i) & operand2_i[31];
    a_abs = a_neg ? -operand1_i : operand1_i;
    b_abs = b_neg ? -operand2_i : operand2_i;
`ifdef MULDIV_DIV_EN
    div_zero = md_is_div(op_i) && (operand2_i == '0);
    div_ovf  = ((op_i == MD_DIV) || (op_i == MD_REM)) &&
               (operand1_i == 32'h8000_0000) && (operand2_i == '1);
    fast_o   = div_zero | div_ovf;
`else
    fast_o   = md_is_div(op_i);
`endif
  end

  always_comb begin
    acc_d     = acc_q;
    b_d       = b_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    mcand     = acc_q[0] ? b_q : '0;
    sum       = {1'b0, acc_q[63:32]} + {1'b0, mcand};
`ifdef MULDIV_DIV_EN
    diff      = {1'b0, acc_q[63:31]} - {2'b00, b_q};
`endif
    if (load_i) begin
      b_d       = b_abs;
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      acc_d     = {32'h0, a_abs};
      // Fast-path results are preloaded so FIX selects them unchanged:
      // remainder in the high half, quotient in the low half, no negation.
`ifdef MULDIV_DIV_EN
      if (div_zero) begin
        acc_d     = {operand1_i, 32'hFFFF_FFFF};
        neg_d     = 1'b0;
        neg_rem_d = 1'b0;
      end else if (div_ovf) begin
        acc_d     = {32'h0, 32'h8000_0000};
        neg_d     = 1'b0;
        neg_rem_d = 1'b0;
      end
`else
      if (md_is_div(op_i)) begin
        acc_d     = '0;
        neg_d     = 1'b0;
        neg_rem_d = 1'b0;
      end
`endif
    end else if (step_i) begin
`ifdef MULDIV_DIV_EN
      if (md_is_div(op_q_i)) begin
        // acc_q[63:31] is the 33-bit shifted partial remainder
        if (!diff[33]) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
        else           acc_d = {acc_q[62:0], 1'b0};
      end else
`endif
      begin
        // product high half accumulates; multiplier shifts out of the LSB
        acc_d = {sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  logic [63:0] prod;
  logic [31:0] quot, rem;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
    case (op_q_i)
      MD_MUL:                       result_o = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[63:32];
      MD_DIV, MD_DIVU:              result_o = quot;
      MD_REM, MD_REMU:              result_o = rem;
      default:                      result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative RV32M multiply/divide sequencer for the EX stage.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start_i, op_i         : request and RV32M funct3 op, sampled in IDLE
//   operand1_i/operand2_i : forwarded rs1 / rs2
//   rd_i                  : destination register, captured at start
//   kill_i                : pipeline flush, aborts without done_o
//   busy_o                : registered, state != IDLE
//   stall_o               : combinational (start_i & ~kill_i) | busy_o
//   done_o                : registered one-cycle result-valid pulse
//   result_o, rd_o        : registered result and destination, held to next done_o
// Macro MULDIV_DIV_EN enables the divide hardware; without it divide ops
// finish one cycle after start with result 0.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] operand1_i,
  input  logic [31:0] operand2_i,
  input  logic [4:0]  rd_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic        load, step, fast;
  logic [31:0] dp_result;

  assign load = (state_q == MD_IDLE) && start_i && !kill_i;
  assign step = (state_q == MD_CALC) && !kill_i;

  muldiv_datapath u_datapath (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .step_i     (step),
    .op_i       (op_i),
    .op_q_i     (op_q),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .fast_o     (fast),
    .result_o   (dp_result)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          rd_d    = rd_i;
          cnt_d   = '0;
          state_d = fast ? MD_FIX : MD_CALC;
        end
      end
      MD_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MD_ITER - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        result_d = dp_result;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        state_d  = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    // Flush overrides everything, including a start presented in IDLE.
    if (kill_i) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      op_d     = op_q;
      rd_d     = rd_q;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy_o   = busy_q;
  assign stall_o  = (start_i & ~kill_i) | busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i, kill_i;
  logic [2:0]  op_i;
  logic [31:0] operand1_i, operand2_i;
  logic [4:0]  rd_i;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  ex_muldiv_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .rd_i       (rd_i),
    .kill_i     (kill_i),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_o       (rd_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
    logic [2:0]  op;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
  endtask

  // Reference model: plain signed/unsigned 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ub = $signed({32'b0, b});
    up = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  return up[63:32];
`ifdef MULDIV_DIV_EN
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Edges from the start edge to the edge that raises done_o.
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 33;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  // Monitor: every done_o pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result_op%0d", e.op), result_o, e.res);
          check("rd_o", rd_o, e.rd);
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Presents a request at a negedge; returns just after the start edge E0.
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    op_i = op; operand1_i = a; operand2_i = b; rd_i = rd; start_i = 1'b1;
    #1;
    check("stall_on_start", stall_o, 1'b1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit noise);
    int lat, busy_cnt;
    bit stall_bad, seen;
    lat = ref_lat(op, a, b);
    drive_start(op, a, b, rd);
    exp_q.push_back('{res: ref_result(op, a, b), rd: rd, cyc: cyc + lat, op: op});
    busy_cnt = 0; stall_bad = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1; break; end
      if (busy_o) busy_cnt++;
      if (!stall_o) stall_bad = 1;
      // a start presented while busy must be ignored
      if (noise && i == 4) begin
        start_i = 1'b1; op_i = 3'($urandom); operand1_i = $urandom; operand2_i = $urandom; rd_i = 5'($urandom);
      end
      if (noise && i == 5) start_i = 1'b0;
    end
    check("done_seen", seen, 1'b1);
    check("busy_cycles", busy_cnt, lat);
    check("stall_while_busy", stall_bad, 1'b0);
    check("stall_in_done_cycle", stall_o, 1'b0);
  endtask

  logic [2:0]  d_op [12] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                             OP_DIVU, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_DIVU};
  logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'd10};
  logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2};

  initial begin
    logic [31:0] prev_res, a, b;
    logic [2:0]  op;
    reset_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
    op_i = '0; operand1_i = '0; operand2_i = '0; rd_i = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_result", result_o, 32'h0);
    check("reset_rd", rd_o, 5'h0);
    check("reset_stall", stall_o, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Known vectors; each issue starts in the previous done cycle (back-to-back).
    for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], 5'(i + 1), 1'b0);

    // Flush sampled at E10 of a MUL, then a new start at E11.
    @(negedge clk);
    prev_res = result_o;
    drive_start(OP_MUL, 32'd1234, 32'd5678, 5'd20);
    repeat (10) @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    check("kill_busy", busy_o, 1'b0);
    check("kill_done", done_o, 1'b0);
    check("kill_result_held", result_o, prev_res);
    @(negedge clk);
    issue(OP_MUL, 32'd12345, 32'd67, 5'd21, 1'b0);

    // start together with kill in IDLE does nothing.
    @(negedge clk);
    op_i = OP_MUL; start_i = 1'b1; kill_i = 1'b1;
    #1;
    check("start_kill_stall", stall_o, 1'b0);
    @(posedge clk);
    #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("start_kill_busy", busy_o, 1'b0);
    repeat (4) @(negedge clk);
    check("start_kill_no_done", done_o, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    drive_start(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midop_reset_busy", busy_o, 1'b0);
    check("midop_reset_done", done_o, 1'b0);
    check("midop_reset_result", result_o, 32'h0);
    check("midop_reset_rd", rd_o, 5'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized ops with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = $urandom_range(0, 3) | 32'hFFFF_FFFC;
        default: ;
      endcase
      issue(op, a, b, 5'($urandom), bit'(i % 3 == 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
